// File: rtl/link_test_initiator.sv
`default_nettype none
// ============================================================================
// link_test_initiator
// Writes a counter/LFSR8 byte pattern to the TX FIFO and checks its echo from
// the RX FIFO against an independently regenerated copy of the same pattern.
// Revision: 1.0
// ============================================================================
module link_test_initiator #(
  parameter int COUNT_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                   CLK,
  input  logic                   PORESET,
  input  logic                   START,
  input  logic [COUNT_WIDTH-1:0] LENGTH,
  input  logic                   MODE,
  input  logic [7:0]             SEED,
  output logic                   TX_WREN,
  output logic [7:0]             TX_WRDATA,
  input  logic                   TX_FULL,
  output logic                   RX_RDEN,
  input  logic [7:0]             RX_RDDATA,
  input  logic                   RX_EMPTY,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   TIMED_OUT,
  output logic [COUNT_WIDTH-1:0] TX_COUNT,
  output logic [COUNT_WIDTH-1:0] RX_COUNT,
  output logic [COUNT_WIDTH-1:0] ERR_COUNT
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W:0] C_IDLE_LIMIT = (IDLE_W+1)'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN  = 2'd1;
  localparam logic [1:0] C_FIN  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [COUNT_WIDTH-1:0] length_q, length_d;
  logic                   mode_q, mode_d;
  logic [7:0]             tx_pat_q, tx_pat_d;
  logic [7:0]             exp_pat_q, exp_pat_d;
  logic [COUNT_WIDTH-1:0] tx_count_q, tx_count_d;
  logic [COUNT_WIDTH-1:0] rx_count_q, rx_count_d;
  logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [IDLE_W-1:0]      idle_q, idle_d;
  logic                   rd_pending_q, rd_pending_d;
  logic                   done_q, done_d;
  logic                   timed_out_q, timed_out_d;

  logic                   tx_wren;
  logic                   rx_rden;
  logic                   busy;
  logic [IDLE_W:0]        idle_inc;
  logic [7:0]             seed_eff;

  function automatic logic [7:0] pat_next(input logic m, input logic [7:0] q);
    return m ? {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]} : q + 8'd1;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge CLK or posedge PORESET) begin
    if (PORESET) begin
      state_q      <= C_IDLE;
      length_q     <= '0;
      mode_q       <= 1'b0;
      tx_pat_q     <= '0;
      exp_pat_q    <= '0;
      tx_count_q   <= '0;
      rx_count_q   <= '0;
      err_count_q  <= '0;
      idle_q       <= '0;
      rd_pending_q <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      length_q     <= length_d;
      mode_q       <= mode_d;
      tx_pat_q     <= tx_pat_d;
      exp_pat_q    <= exp_pat_d;
      tx_count_q   <= tx_count_d;
      rx_count_q   <= rx_count_d;
      err_count_q  <= err_count_d;
      idle_q       <= idle_d;
      rd_pending_q <= rd_pending_d;
      done_q       <= done_d;
      timed_out_q  <= timed_out_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    length_d     = length_q;
    mode_d       = mode_q;
    tx_pat_d     = tx_pat_q;
    exp_pat_d    = exp_pat_q;
    tx_count_d   = tx_count_q;
    rx_count_d   = rx_count_q;
    err_count_d  = err_count_q;
    idle_d       = idle_q;
    rd_pending_d = rx_rden;
    done_d       = done_q;
    timed_out_d  = timed_out_q;
    idle_inc     = {1'b0, idle_q} + 1'b1;
    // An all-zero LFSR state would lock up, so seed 0 is promoted to 1.
    seed_eff     = (MODE && (SEED == 8'h00)) ? 8'h01 : SEED;

    if (START && (state_q != C_RUN)) begin
      length_d     = LENGTH;
      mode_d       = MODE;
      tx_pat_d     = seed_eff;
      exp_pat_d    = seed_eff;
      tx_count_d   = '0;
      rx_count_d   = '0;
      err_count_d  = '0;
      idle_d       = '0;
      rd_pending_d = 1'b0;
      timed_out_d  = 1'b0;
      if (LENGTH == '0) begin
        state_d = C_FIN;
        done_d  = 1'b1;
      end else begin
        state_d = C_RUN;
        done_d  = 1'b0;
      end
    end else if (state_q == C_RUN) begin
      if (tx_wren) begin
        tx_count_d = sat_inc(tx_count_q);
        tx_pat_d   = pat_next(mode_q, tx_pat_q);
      end
      if (rd_pending_q) begin
        rx_count_d = sat_inc(rx_count_q);
        exp_pat_d  = pat_next(mode_q, exp_pat_q);
        idle_d     = '0;
        if (RX_RDDATA != exp_pat_q) begin
          err_count_d = sat_inc(err_count_q);
        end
        if (sat_inc(rx_count_q) == length_q) begin
          state_d = C_FIN;
          done_d  = 1'b1;
        end
      end else if (idle_inc >= C_IDLE_LIMIT) begin
        state_d     = C_FIN;
        done_d      = 1'b1;
        timed_out_d = 1'b1;
      end else begin
        idle_d = idle_inc[IDLE_W-1:0];
      end
    end
  end

  always_comb begin
    busy    = (state_q == C_RUN);
    tx_wren = busy && !TX_FULL && (tx_count_q != length_q);
    rx_rden = busy && !RX_EMPTY && !rd_pending_q && (rx_count_q != length_q);
  end

  assign TX_WREN   = tx_wren;
  assign TX_WRDATA = tx_pat_q;
  assign RX_RDEN   = rx_rden;
  assign BUSY      = busy;
  assign DONE      = done_q;
  assign TIMED_OUT = timed_out_q;
  assign TX_COUNT  = tx_count_q;
  assign RX_COUNT  = rx_count_q;
  assign ERR_COUNT = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_link_test_initiator.sv
`default_nettype none
// ============================================================================
// tb_link_test_initiator
// Directed bench with a loopback FIFO model and a TX-byte scoreboard.
// Revision: 1.0
// ============================================================================
module tb_link_test_initiator;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          poreset, start, mode, tx_full;
  logic [CW-1:0] length;
  logic [7:0]    seed;
  logic          tx_wren, rx_rden, busy, done, timed_out;
  logic [7:0]    tx_wrdata, rx_rddata;
  logic          rx_empty;
  logic [CW-1:0] tx_count, rx_count, err_count;

  logic          disconnect, fifo_flush;
  logic [7:0]    mem [0:255];
  int            wr_ptr = 0, rd_ptr = 0, corrupt_idx = -1;
  int            full_wrens = 0, rden_cnt = 0;
  logic [7:0]    tx_exp [$];
  int            checks = 0, errors = 0;

  always #5 clk = ~clk;

  link_test_initiator #(.COUNT_WIDTH(CW), .TIMEOUT_CYCLES(50)) dut (
    .CLK(clk), .PORESET(poreset), .START(start), .LENGTH(length), .MODE(mode),
    .SEED(seed), .TX_WREN(tx_wren), .TX_WRDATA(tx_wrdata), .TX_FULL(tx_full),
    .RX_RDEN(rx_rden), .RX_RDDATA(rx_rddata), .RX_EMPTY(rx_empty), .BUSY(busy),
    .DONE(done), .TIMED_OUT(timed_out), .TX_COUNT(tx_count), .RX_COUNT(rx_count),
    .ERR_COUNT(err_count)
  );

  assign rx_empty = (wr_ptr == rd_ptr);

  // Loopback FIFO: optional single-byte corruption, or dropped writes when disconnected.
  always @(posedge clk) begin
    if (fifo_flush) begin
      wr_ptr <= 0;
      rd_ptr <= 0;
    end else begin
      if (tx_wren && !disconnect) begin
        mem[wr_ptr[7:0]] <= tx_wrdata ^ ((wr_ptr == corrupt_idx) ? 8'h01 : 8'h00);
        wr_ptr <= wr_ptr + 1;
      end
      if (rx_rden) begin
        rx_rddata <= mem[rd_ptr[7:0]];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every TX write pops the next expected byte.
  always @(negedge clk) begin
    if (!poreset) begin
      if (tx_wren) begin
        if (tx_full) full_wrens++;
        if (tx_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: actual write %0h required none", tx_wrdata);
        end else begin
          chk("tx_data", tx_wrdata, tx_exp.pop_front());
        end
      end
      if (rx_rden) begin
        rden_cnt++;
        chk("rden_nonempty", rx_empty, 1'b0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [CW-1:0] len, input logic m, input logic [7:0] s);
    length = len;
    mode   = m;
    seed   = s;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic flush();
    fifo_flush = 1'b1;
    tick(1);
    fifo_flush = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 1;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_wait: actual DONE=0 after %0d cycles required DONE=1", k);
    end
  endtask

  task automatic wait_tx(input int n);
    int g = 0;
    while (tx_count != CW'(n) && g < 200) begin
      tick(1);
      g++;
    end
    chk("tx_reach", tx_count, n);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timed_out"}, timed_out, 0);
    chk({tag, "_tx_count"}, tx_count, 0);
    chk({tag, "_rx_count"}, rx_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_tx_wren"}, tx_wren, 0);
    chk({tag, "_rx_rden"}, rx_rden, 0);
  endtask

  initial begin
    int k;
    int r0;
    poreset = 1'b1; start = 1'b0; length = '0; mode = 1'b0; seed = 8'h00;
    tx_full = 1'b0; disconnect = 1'b0; fifo_flush = 1'b1;
    tick(3);
    chk_all_zero("reset");
    poreset = 1'b0;
    fifo_flush = 1'b0;
    tick(2);

    // Counter mode wrapping through 0xFF.
    tx_exp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    pulse_start(4, 1'b0, 8'hFE);
    chk("t1_busy_n1", busy, 1);
    wait_done(100, k);
    chk("t1_done", done, 1);
    chk("t1_rx_count", rx_count, 4);
    chk("t1_tx_count", tx_count, 4);
    chk("t1_err_count", err_count, 0);
    chk("t1_timed_out", timed_out, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_tx_left", tx_exp.size(), 0);

    // LFSR mode from seed 0, echo byte 3 corrupted.
    flush();
    corrupt_idx = 3;
    tx_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    pulse_start(6, 1'b1, 8'h00);
    wait_done(100, k);
    chk("t2_err_count", err_count, 1);
    chk("t2_rx_count", rx_count, 6);
    chk("t2_tx_count", tx_count, 6);
    chk("t2_timed_out", timed_out, 0);
    chk("t2_tx_left", tx_exp.size(), 0);
    corrupt_idx = -1;

    // TX_FULL held for 20 cycles mid-run.
    flush();
    tx_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
               8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B};
    pulse_start(12, 1'b0, 8'h10);
    wait_tx(5);
    tx_full = 1'b1;
    full_wrens = 0;
    tick(20);
    chk("t3_full_wrens", full_wrens, 0);
    chk("t3_tx_held", tx_count, 5);
    tx_full = 1'b0;
    wait_done(200, k);
    chk("t3_rx_count", rx_count, 12);
    chk("t3_err_count", err_count, 0);
    chk("t3_timed_out", timed_out, 0);
    chk("t3_tx_left", tx_exp.size(), 0);

    // Disconnected loopback: timeout 50 cycles after START.
    flush();
    disconnect = 1'b1;
    tx_exp = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    pulse_start(10, 1'b0, 8'h30);
    wait_done(200, k);
    chk("t4_latency", k, 50);
    chk("t4_timed_out", timed_out, 1);
    chk("t4_tx_count", tx_count, 10);
    chk("t4_rx_count", rx_count, 0);
    chk("t4_busy", busy, 0);
    chk("t4_tx_left", tx_exp.size(), 0);
    disconnect = 1'b0;

    // LENGTH=0 finishes immediately; START during RUN is ignored.
    flush();
    r0 = rden_cnt;
    pulse_start(0, 1'b0, 8'h55);
    chk("t5_done_n1", done, 1);
    chk("t5_busy_n1", busy, 0);
    chk("t5_timed_out", timed_out, 0);
    tick(3);
    chk("t5_no_rden", rden_cnt - r0, 0);
    chk("t5_tx_count", tx_count, 0);
    tx_exp = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47};
    pulse_start(8, 1'b0, 8'h40);
    tick(2);
    pulse_start(3, 1'b1, 8'h99);
    wait_done(200, k);
    chk("t5_tx_count_run", tx_count, 8);
    chk("t5_rx_count_run", rx_count, 8);
    chk("t5_err_count_run", err_count, 0);
    chk("t5_tx_left", tx_exp.size(), 0);

    // Reset mid-run, then a clean restart from SEED.
    flush();
    for (int i = 0; i < 100; i++) tx_exp.push_back(8'(8'h80 + i));
    pulse_start(100, 1'b0, 8'h80);
    wait_tx(5);
    poreset = 1'b1;
    #1;
    chk_all_zero("t6_reset");
    tx_exp.delete();
    fifo_flush = 1'b1;
    tick(2);
    poreset = 1'b0;
    fifo_flush = 1'b0;
    tick(1);
    tx_exp = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
    pulse_start(6, 1'b0, 8'h80);
    wait_done(100, k);
    chk("t6_rx_count", rx_count, 6);
    chk("t6_tx_count", tx_count, 6);
    chk("t6_err_count", err_count, 0);
    chk("t6_tx_left", tx_exp.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/link_test_initiator.md
# link_test_initiator

Arbiter-side traffic initiator for host-link bring-up. It writes a deterministic byte pattern into the TX FIFO (arbiter → transport direction) and reads the echoed bytes back from the RX FIFO (transport → arbiter). Each received byte is checked against an independently regenerated copy of the pattern. Errors, progress and timeout status are reported to a control/status register block. It sits in the CLK domain in place of the arbiter and drives the write side of the TX dual-clock FIFO and the read side of the RX dual-clock FIFO.

## Interface
- COUNT_WIDTH, 32, width of LENGTH and all counters
- TIMEOUT_CYCLES, 1000000, CLK cycles without an accepted RX byte before the run aborts
- CLK  in  1  system clock; the only clock
- PORESET  in  1  reset, asynchronous, active-high
- START  in  1  single-cycle pulse that begins a run
- LENGTH  in  COUNT_WIDTH  bytes to send and check; sampled on START
- MODE  in  1  0 = incrementing counter, 1 = LFSR8; sampled on START
- SEED  in  8  first pattern byte; sampled on START
- TX_WREN  out  1  TX FIFO write enable
- TX_WRDATA  out  8  TX FIFO write data
- TX_FULL  in  1  TX FIFO full
- RX_RDEN  out  1  RX FIFO read enable
- RX_RDDATA  in  8  RX FIFO read data; valid in the cycle after RX_RDEN
- RX_EMPTY  in  1  RX FIFO empty
- BUSY  out  1  run in progress
- DONE  out  1  run finished; held until the next START
- TIMED_OUT  out  1  run ended by timeout; held until the next START
- TX_COUNT, RX_COUNT, ERR_COUNT  out  COUNT_WIDTH each  bytes written, bytes checked, mismatches

## Operation
- States: IDLE, RUN, FIN. Reset enters IDLE; every output and register resets to 0.
- IDLE or FIN, START=1:
  - Latch LENGTH, MODE and SEED.
  - Clear all counters, DONE and TIMED_OUT.
  - Load both pattern generators with SEED. In LFSR mode, SEED=0x00 is replaced by 0x01.
  - Go to RUN, or go directly to FIN with DONE=1 if LENGTH=0.
- START while in RUN is ignored.
- Pattern generator:
  - Counter mode: byte i = (SEED + i) mod 256.
  - LFSR mode: next = {q[6:0], q[7]^q[5]^q[4]^q[3]}. With seed 0x01 the sequence is 01,02,04,08,11,23.
  - The TX generator and the expected-value generator are separate copies. Each advances only when its own byte is consumed.
- TX side:
  - TX_WREN = RUN & ~TX_FULL & (TX_COUNT != LENGTH), combinational.
  - TX_WRDATA = current TX pattern register.
  - On a write, TX_COUNT increments and the TX generator advances.
- RX side:
  - RX_RDEN = RUN & ~RX_EMPTY & ~rd_pending & (RX_COUNT != LENGTH), combinational.
  - rd_pending is a register set the cycle after RX_RDEN.
  - While rd_pending=1, compare RX_RDDATA against the expected byte, increment RX_COUNT, advance the expected generator, and increment ERR_COUNT if the bytes differ.
  - One read is outstanding at most, so throughput is one byte per 2 cycles.
- Completion: a compare that makes RX_COUNT == LENGTH moves the block to FIN with DONE=1 and BUSY=0.
- Timeout:
  - The idle counter clears on START and on every compare, and increments in RUN otherwise.
  - The counter does not advance while rd_pending=1.
  - When it reaches TIMEOUT_CYCLES-1, the block goes to FIN with DONE=1 and TIMED_OUT=1.
- Counter limits: all counters saturate at 2^COUNT_WIDTH-1 and never wrap.
- BUSY = (state == RUN).

## Timing
- START at cycle n: BUSY=1 from n+1. The first TX_WREN can occur at n+1.
- RX_RDEN at cycle k: compare happens at k+1, and the counters update at k+2.
- DONE rises the cycle after the final compare.
- Completion and timeout in the same cycle: completion wins, TIMED_OUT=0.
- TX_FULL and RX_EMPTY are used combinationally. No write is issued while full and no read while empty.
- PORESET asserted mid-run:
  - Immediate return to IDLE; all outputs go to 0.
  - The FIFO contents are not the block's concern.

## Test plan
- Counter mode, SEED=0xFE, LENGTH=4, ideal loopback FIFO model:
  - TX_WRDATA sequence is FE,FF,00,01.
  - End state: DONE=1, RX_COUNT=4, ERR_COUNT=0, TIMED_OUT=0.
- LFSR mode, SEED=0x00, LENGTH=6:
  - Writes are 01,02,04,08,11,23.
  - Echo corrupted at byte 3 (0x08→0x09) gives ERR_COUNT=1 and RX_COUNT=6.
- TX_FULL held high for 20 cycles mid-run: no TX_WREN during that window; the sequence resumes with no gap or duplicate.
- Loopback disconnected, TIMEOUT_CYCLES=50, LENGTH=10:
  - DONE=1 and TIMED_OUT=1 exactly 50 cycles after START.
  - End state: TX_COUNT=10, RX_COUNT=0.
- LENGTH=0: DONE=1 at cycle n+1 with no TX_WREN or RX_RDEN. A second START while BUSY is ignored, and its LENGTH is not latched.
- PORESET pulsed mid-run at byte 5 of 100:
  - All outputs go to 0 and the state is IDLE.
  - A following START restarts cleanly from SEED.
